// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//   Receive side of a multiplexed 7-segment scan. Each stable dwell of
//   {an_in, seg_in} is sampled once, after it has been steady for
//   SETTLE_CYCLES cycles. The segment pattern is decoded back to a hex nibble,
//   and the nibbles are assembled into a 32-bit word. A frame completes once
//   all eight digits have been seen. A clean frame updates `number` and pulses
//   `valid`; a frame containing a bad sample pulses `err` instead.
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  an_in,
  input  logic [6:0]  seg_in,
  output logic [31:0] number,
  output logic        valid,
  output logic        err
);

  localparam int unsigned CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  // Previous-cycle inputs and dwell tracking
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          same;
  logic          sample;

  // Frame assembly state
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          bad_q, bad_d;

  // Outputs
  logic [31:0]   number_q, number_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Anode decode
  logic [7:0]    an_act;
  logic          an_none;
  logic          an_multi;
  logic [2:0]    dig_idx;

  // Segment decode
  logic [4:0]    dec;

  // Maps an active-low {g,f,e,d,c,b,a} pattern to {ok, nibble}.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg_n);
    logic [6:0] s;
    s = ~seg_n;
    case (s)
      7'h3F:   decode_seg = {1'b1, 4'h0};
      7'h06:   decode_seg = {1'b1, 4'h1};
      7'h5B:   decode_seg = {1'b1, 4'h2};
      7'h4F:   decode_seg = {1'b1, 4'h3};
      7'h66:   decode_seg = {1'b1, 4'h4};
      7'h6D:   decode_seg = {1'b1, 4'h5};
      7'h7D:   decode_seg = {1'b1, 4'h6};
      7'h07:   decode_seg = {1'b1, 4'h7};
      7'h7F:   decode_seg = {1'b1, 4'h8};
      7'h6F:   decode_seg = {1'b1, 4'h9};
      7'h77:   decode_seg = {1'b1, 4'hA};
      7'h7C:   decode_seg = {1'b1, 4'hB};
      7'h39:   decode_seg = {1'b1, 4'hC};
      7'h5E:   decode_seg = {1'b1, 4'hD};
      7'h79:   decode_seg = {1'b1, 4'hE};
      7'h71:   decode_seg = {1'b1, 4'hF};
      default: decode_seg = 5'b0_0000;
    endcase
  endfunction

  // Dwell counter: counts the closed cycles of the current dwell and asserts
  // `sample` exactly on the edge that closes the SETTLE_CYCLES-th cycle.
  always_comb begin
    cnt_d  = cnt_q;
    sample = 1'b0;
    same   = (an_in == an_q) && (seg_in == seg_q);
    if (!same) begin
      cnt_d  = ONE_C;
      sample = (SETTLE_C == ONE_C);
    end else if (cnt_q != SETTLE_C) begin
      cnt_d  = cnt_q + ONE_C;
      sample = (cnt_d == SETTLE_C);
    end
  end

  // Anode classification: blank, exactly one digit (with its index), or several.
  always_comb begin
    an_act   = ~an_in;
    an_none  = (an_act == '0);
    an_multi = ((an_act & (an_act - 8'd1)) != '0);
    dig_idx  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (an_act[i]) dig_idx = 3'(i);
    end
    dec = decode_seg(seg_in);
  end

  // Frame assembly and completion; completion is judged on the next-state
  // seen/bad so the last digit's own sample counts. clr overrides everything.
  always_comb begin
    seen_d   = seen_q;
    shadow_d = shadow_q;
    bad_d    = bad_q;
    number_d = number_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (clr) begin
      seen_d = '0;
      bad_d  = 1'b0;
    end else if (sample && !an_none) begin
      if (an_multi) begin
        bad_d = 1'b1;
      end else begin
        seen_d[dig_idx] = 1'b1;
        if (dec[4]) shadow_d[4*dig_idx +: 4] = dec[3:0];
        else        bad_d = 1'b1;
      end
      if (seen_d == 8'hFF) begin
        if (bad_d) begin
          err_d = 1'b1;
        end else begin
          number_d = shadow_d;
          valid_d  = 1'b1;
        end
        seen_d = '0;
        bad_d  = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      cnt_q    <= '0;
      seen_q   <= '0;
      shadow_q <= '0;
      bad_q    <= 1'b0;
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      an_q     <= an_in;
      seg_q    <= seg_in;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      shadow_q <= shadow_d;
      bad_q    <= bad_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign number = number_q;
  assign valid  = valid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: table of whole frames plus
// hand-written sequences for latency, glitches, multi-anode, reset and clr.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  an_in = 8'hFF;
  logic [6:0]  seg_in = 7'h7F;
  logic [31:0] number;
  logic        valid;
  logic        err;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .an_in  (an_in),
    .seg_in (seg_in),
    .number (number),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err) ecnt++;
    if (valid && err) begin
      errors++;
      $display("FAIL both_high: valid=%0b err=%0b required not both 1", valid, err);
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h3F; 4'h1: enc = 7'h06; 4'h2: enc = 7'h5B; 4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66; 4'h5: enc = 7'h6D; 4'h6: enc = 7'h7D; 4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F; 4'h9: enc = 7'h6F; 4'hA: enc = 7'h77; 4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39; 4'hD: enc = 7'h5E; 4'hE: enc = 7'h79; default: enc = 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; leaves just after a rising edge.
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [31:0] w, input int lo, input int hi,
                      input int bad_digit, input logic [6:0] bad_seg,
                      input int short_digit, input int short_len);
    logic [7:0] an;
    logic [6:0] seg;
    for (int i = lo; i <= hi; i++) begin
      an  = ~(8'h01 << i);
      seg = (i == bad_digit) ? bad_seg : ~enc(w[4*i +: 4]);
      drive(an, seg, (i == short_digit) ? short_len : 16);
    end
  endtask

  task automatic scan_all(input logic [31:0] w);
    scan(w, 0, 7, -1, 7'h7F, -1, 0);
  endtask

  typedef struct {
    logic [31:0] word;
    int          bad_digit;
    logic [6:0]  bad_seg;
    int          exp_v;
    int          exp_e;
    logic [31:0] exp_num;
  } frame_t;

  frame_t tbl[6];

  initial begin
    int v0, e0;
    logic [6:0] s7;

    tbl[0] = '{32'hDEADBEEF, -1, 7'h7F, 1, 0, 32'hDEADBEEF};
    tbl[1] = '{32'hDEADBEEF, -1, 7'h7F, 1, 0, 32'hDEADBEEF};
    tbl[2] = '{32'hDEADBEEF,  5, 7'h7E, 0, 1, 32'hDEADBEEF};
    tbl[3] = '{32'h01234567, -1, 7'h7F, 1, 0, 32'h01234567};
    tbl[4] = '{32'hCAFEF00D,  2, 7'h7F, 0, 1, 32'h01234567};
    tbl[5] = '{32'h89ABCDEF, -1, 7'h7F, 1, 0, 32'h89ABCDEF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_number", number, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    drive(8'hFF, 7'h7F, 3);

    // Whole-frame table
    for (int t = 0; t < 6; t++) begin
      v0 = vcnt; e0 = ecnt;
      scan(tbl[t].word, 0, 7, tbl[t].bad_digit, tbl[t].bad_seg, -1, 0);
      chk($sformatf("tbl%0d_valid_cnt", t), 32'(vcnt - v0), 32'(tbl[t].exp_v));
      chk($sformatf("tbl%0d_err_cnt", t), 32'(ecnt - e0), 32'(tbl[t].exp_e));
      chk($sformatf("tbl%0d_number", t), number, tbl[t].exp_num);
    end

    // Latency: valid high only in the cycle after digit 7's 4th edge
    scan(32'h55AA33CC, 0, 6, -1, 7'h7F, -1, 0);
    s7 = ~enc(4'h5);
    an_in = 8'h7F; seg_in = s7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_edge%0d_valid", k), {31'b0, valid}, (k == 4) ? 32'h1 : 32'h0);
    end
    chk("latency_number", number, 32'h55AA33CC);
    drive(8'h7F, s7, 11);

    // Glitch: digit 3 held 3 cycles is never sampled
    v0 = vcnt; e0 = ecnt;
    scan(32'hFEEDC0DE, 0, 7, -1, 7'h7F, 3, 3);
    chk("glitch_pass1_valid", 32'(vcnt - v0), 32'd0);
    chk("glitch_pass1_err", 32'(ecnt - e0), 32'd0);
    scan(32'hFEEDC0DE, 0, 3, -1, 7'h7F, -1, 0);
    chk("glitch_pass2_valid", 32'(vcnt - v0), 32'd1);
    chk("glitch_pass2_number", number, 32'hFEEDC0DE);

    // Several anodes low mid-frame
    v0 = vcnt; e0 = ecnt;
    scan(32'h11223344, 0, 3, -1, 7'h7F, -1, 0);
    drive(8'h00, ~enc(4'h1), 10);
    scan(32'h11223344, 4, 7, -1, 7'h7F, -1, 0);
    chk("multi_err", 32'(ecnt - e0), 32'd1);
    chk("multi_valid", 32'(vcnt - v0), 32'd0);
    chk("multi_number", number, 32'hFEEDC0DE);

    // Reset mid-frame
    scan(32'h12345678, 0, 4, -1, 7'h7F, -1, 0);
    an_in = 8'hFF; seg_in = 7'h7F;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_number", number, 32'h0);
    chk("midrst_valid", {31'b0, valid}, 32'h0);
    chk("midrst_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    drive(8'hFF, 7'h7F, 2);
    v0 = vcnt; e0 = ecnt;
    scan(32'h12345678, 5, 7, -1, 7'h7F, -1, 0);
    chk("midrst_partial_valid", 32'(vcnt - v0), 32'd0);
    scan_all(32'h12345678);
    chk("midrst_full_valid", 32'(vcnt - v0), 32'd1);
    chk("midrst_full_number", number, 32'h12345678);
    // Drop the leftover partial frame (digits 5..7)
    clr = 1'b1;
    drive(8'hFF, 7'h7F, 1);
    clr = 1'b0;

    // clr on digit 7's sample edge, with blanks interleaved
    v0 = vcnt; e0 = ecnt;
    scan(32'h9876FEDC, 0, 6, -1, 7'h7F, -1, 0);
    drive(8'hFF, 7'h7F, 6);
    an_in = 8'h7F; seg_in = ~enc(4'h9);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    drive(8'h7F, ~enc(4'h9), 12);
    drive(8'hFF, 7'h7F, 5);
    chk("clr_valid", 32'(vcnt - v0), 32'd0);
    chk("clr_err", 32'(ecnt - e0), 32'd0);
    chk("clr_number_kept", number, 32'h12345678);
    scan_all(32'h9876FEDC);
    chk("clr_next_valid", 32'(vcnt - v0), 32'd1);
    chk("clr_next_number", number, 32'h9876FEDC);

    drive(8'hFF, 7'h7F, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
